// File: rtl/riscv_mpsoc_pkg.sv
// Shared definitions for the per-core debug unit: address map, breakpoint
// types, HIT bit positions and the bus-access FSM states.
package riscv_mpsoc_pkg;

  localparam logic [13:0] ADR_CTRL    = 14'h0000;
  localparam logic [13:0] ADR_HIT     = 14'h0001;
  localparam logic [13:0] ADR_IE      = 14'h0002;
  localparam logic [13:0] ADR_CAUSE   = 14'h0003;
  localparam logic [13:0] ADR_BP_BASE = 14'h0010;
  localparam logic [13:0] ADR_NPC     = 14'h2000;
  localparam logic [13:0] ADR_PPC     = 14'h2001;
  localparam logic [8:0]  ADR_GPR_PFX = 9'h080;   // adr[13:5] of 0x1000-0x101F
  localparam logic [1:0]  ADR_CSR_PFX = 2'b11;    // adr[13:12] of 0x3000-0x3FFF

  localparam int HIT_SS  = 0;
  localparam int HIT_BR  = 1;
  localparam int HIT_EXC = 2;
  localparam int HIT_BP0 = 4;

  typedef enum logic [1:0] {
    BP_INSTR  = 2'd0,
    BP_DREAD  = 2'd1,
    BP_DWRITE = 2'd2,
    BP_DANY   = 2'd3
  } bp_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_WAIT   = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/riscv_dbg_bp_match.sv
// Single hardware breakpoint comparator: instruction-address or filtered
// data-address match against one programmed breakpoint address.
module riscv_dbg_bp_match
  import riscv_mpsoc_pkg::*;
#(
  parameter int PLEN = 64
) (
  input  logic            en_i,
  input  bp_type_e        type_i,
  input  logic [PLEN-1:0] adr_i,
  input  logic            ex_valid_i,
  input  logic [PLEN-1:0] ex_pc_i,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [PLEN-1:0] mem_adr_i,
  output logic            hit_o
);

  logic match;

  always_comb begin
    match = 1'b0;
    unique case (type_i)
      BP_INSTR:  match = ex_valid_i & (ex_pc_i == adr_i);
      BP_DREAD:  match = mem_req_i & ~mem_we_i & (mem_adr_i == adr_i);
      BP_DWRITE: match = mem_req_i &  mem_we_i & (mem_adr_i == adr_i);
      BP_DANY:   match = mem_req_i & (mem_adr_i == adr_i);
    endcase
  end

  assign hit_o = en_i & match;

endmodule

// File: rtl/riscv_dbg_unit.sv
// Per-core debug responder: debug-bus register access, core GPR/CSR/PC
// access ports, hardware breakpoints and hit reporting.
//   state     | meaning
//   ST_IDLE   | waiting for dbg_stb_i
//   ST_ACCESS | core strobe / register write, read data captured
//   ST_DONE   | dbg_ack_o high for this single cycle
//   ST_WAIT   | waiting for the controller to drop dbg_stb_i
module riscv_dbg_unit
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int PLEN        = 64,
  parameter int BREAKPOINTS = 3,
  parameter int EXC         = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dbg_stall_i,
  input  logic            dbg_stb_i,
  input  logic            dbg_we_i,
  input  logic [PLEN-1:0] dbg_adr_i,
  input  logic [XLEN-1:0] dbg_dat_i,
  output logic [XLEN-1:0] dbg_dat_o,
  output logic            dbg_ack_o,
  output logic            dbg_bp_o,
  input  logic            ex_valid_i,
  input  logic [PLEN-1:0] ex_pc_i,
  input  logic            ex_branch_i,
  input  logic [EXC-1:0]  ex_exception_i,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [PLEN-1:0] mem_adr_i,
  output logic            du_stall_o,
  output logic            du_flush_o,
  output logic            du_re_rf_o,
  output logic            du_we_rf_o,
  output logic            du_re_csr_o,
  output logic            du_we_csr_o,
  output logic            du_we_pc_o,
  output logic [11:0]     du_addr_o,
  output logic [XLEN-1:0] du_dato_o,
  input  logic [XLEN-1:0] du_dati_rf_i,
  input  logic [XLEN-1:0] du_dati_csr_i,
  input  logic [XLEN-1:0] du_npc_i,
  input  logic [XLEN-1:0] du_ppc_i
);

  localparam int HW = HIT_BP0 + BREAKPOINTS;
  localparam int CW = (EXC > 1) ? $clog2(EXC) : 1;

  dbg_state_e state_q, state_d;
  logic [1:0]                       ctrl_q, ctrl_d;
  logic [HW-1:0]                    hit_q, hit_d, hit_set, hit_clr;
  logic [EXC-1:0]                   ie_q, ie_d, exc_masked;
  logic [CW-1:0]                    cause_q, cause_d;
  logic [BREAKPOINTS-1:0][2:0]      bpctrl_q, bpctrl_d;
  logic [BREAKPOINTS-1:0][PLEN-1:0] bpadr_q, bpadr_d;
  logic [BREAKPOINTS-1:0]           bp_hit;
  logic [XLEN-1:0]                  rdata_q, rdata_d, rd;
  logic bp_q, bp_d, stall_q, pc_written_q, pc_written_d, flush_q, flush_d;

  logic [13:0] a, bp_off;
  logic [2:0]  bp_sel;
  logic is_gpr, is_csr, is_npc, is_ppc, is_core, in_bp, acc, wr, core_ok;
  logic unused_adr;

  assign a          = dbg_adr_i[13:0];
  assign unused_adr = ^dbg_adr_i[PLEN-1:14];
  assign is_gpr     = (a[13:5] == ADR_GPR_PFX);
  assign is_csr     = (a[13:12] == ADR_CSR_PFX);
  assign is_npc     = (a == ADR_NPC);
  assign is_ppc     = (a == ADR_PPC);
  assign is_core    = is_gpr | is_csr | is_npc | is_ppc;
  assign bp_off     = a - ADR_BP_BASE;   // wraps high for a < base
  assign bp_sel     = bp_off[3:1];
  assign in_bp      = (bp_off < 14'(2 * BREAKPOINTS));

  assign acc     = (state_q == ST_ACCESS);
  assign wr      = acc & dbg_we_i;
  assign core_ok = acc & dbg_stall_i;

  assign du_re_rf_o  = core_ok & ~dbg_we_i & is_gpr;
  assign du_we_rf_o  = core_ok &  dbg_we_i & is_gpr;
  assign du_re_csr_o = core_ok & ~dbg_we_i & is_csr;
  assign du_we_csr_o = core_ok &  dbg_we_i & is_csr;
  assign du_we_pc_o  = core_ok &  dbg_we_i & is_npc;
  assign du_addr_o   = !acc ? 12'h000 : (is_csr ? a[11:0] : {7'b0, a[4:0]});
  assign du_dato_o   = acc ? dbg_dat_i : '0;

  assign dbg_ack_o  = (state_q == ST_DONE);
  assign dbg_dat_o  = (state_q == ST_DONE) ? rdata_q : '0;
  assign dbg_bp_o   = bp_q;
  assign du_stall_o = dbg_stall_i | bp_q;
  assign du_flush_o = flush_q;

  for (genvar g = 0; g < BREAKPOINTS; g++) begin : g_bp
    riscv_dbg_bp_match #(.PLEN(PLEN)) u_bp_match (
      .en_i       (bpctrl_q[g][0]),
      .type_i     (bp_type_e'(bpctrl_q[g][2:1])),
      .adr_i      (bpadr_q[g]),
      .ex_valid_i (ex_valid_i),
      .ex_pc_i    (ex_pc_i),
      .mem_req_i  (mem_req_i),
      .mem_we_i   (mem_we_i),
      .mem_adr_i  (mem_adr_i),
      .hit_o      (bp_hit[g])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (dbg_stb_i) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = dbg_stb_i ? ST_WAIT : ST_IDLE;
      ST_WAIT:   if (!dbg_stb_i) state_d = ST_IDLE;
    endcase
  end

  // Core-side reads are only meaningful while the pipeline is held.
  always_comb begin
    rd = '0;
    if (is_core) begin
      if (dbg_stall_i) begin
        if (is_gpr)      rd = du_dati_rf_i;
        else if (is_csr) rd = du_dati_csr_i;
        else if (is_npc) rd = du_npc_i;
        else             rd = du_ppc_i;
      end
    end else if (a == ADR_CTRL)  rd = XLEN'(ctrl_q);
    else if (a == ADR_HIT)       rd = XLEN'(hit_q);
    else if (a == ADR_IE)        rd = XLEN'(ie_q);
    else if (a == ADR_CAUSE)     rd = XLEN'(cause_q);
    else if (in_bp) begin
      for (int n = 0; n < BREAKPOINTS; n++)
        if (bp_sel == 3'(n)) rd = bp_off[0] ? XLEN'(bpadr_q[n]) : XLEN'(bpctrl_q[n]);
    end
    rdata_d = acc ? rd : rdata_q;
  end

  always_comb begin
    ctrl_d       = ctrl_q;
    ie_d         = ie_q;
    cause_d      = cause_q;
    bpctrl_d     = bpctrl_q;
    bpadr_d      = bpadr_q;
    hit_clr      = '0;
    hit_set      = '0;
    pc_written_d = pc_written_q;
    flush_d      = 1'b0;
    exc_masked   = ex_exception_i & ie_q;

    if (wr) begin
      if (a == ADR_CTRL) ctrl_d  = dbg_dat_i[1:0];
      if (a == ADR_HIT)  hit_clr = dbg_dat_i[HW-1:0];
      if (a == ADR_IE)   ie_d    = dbg_dat_i[EXC-1:0];
      for (int n = 0; n < BREAKPOINTS; n++) begin
        if (in_bp && bp_sel == 3'(n)) begin
          if (bp_off[0]) bpadr_d[n]  = dbg_dat_i[PLEN-1:0];
          else           bpctrl_d[n] = dbg_dat_i[2:0];
        end
      end
    end

    if (!dbg_stall_i) begin
      hit_set[HIT_SS]          = ex_valid_i & ctrl_q[0];
      hit_set[HIT_BR]          = ex_valid_i & ex_branch_i & ctrl_q[1];
      hit_set[HIT_EXC]         = |exc_masked;
      hit_set[HW-1:HIT_BP0]    = bp_hit;
    end
    if (hit_set[HIT_EXC]) begin
      for (int i = EXC - 1; i >= 0; i--)
        if (exc_masked[i]) cause_d = CW'(i);
    end
    hit_d = (hit_q & ~hit_clr) | hit_set;
    bp_d  = |hit_set;

    if (du_we_pc_o) pc_written_d = 1'b1;
    if (stall_q && !dbg_stall_i && pc_written_q) begin
      flush_d      = 1'b1;
      pc_written_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      hit_q        <= '0;
      ie_q         <= '0;
      cause_q      <= '0;
      bpctrl_q     <= '0;
      bpadr_q      <= '0;
      rdata_q      <= '0;
      bp_q         <= 1'b0;
      stall_q      <= 1'b0;
      pc_written_q <= 1'b0;
      flush_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      hit_q        <= hit_d;
      ie_q         <= ie_d;
      cause_q      <= cause_d;
      bpctrl_q     <= bpctrl_d;
      bpadr_q      <= bpadr_d;
      rdata_q      <= rdata_d;
      bp_q         <= bp_d;
      stall_q      <= dbg_stall_i;
      pc_written_q <= pc_written_d;
      flush_q      <= flush_d;
    end
  end

endmodule

// File: tb/tb_riscv_dbg_unit.sv
// Scoreboard bench for riscv_dbg_unit: bus accesses, core strobes,
// breakpoint/exception hits and the NPC-write flush.
module tb_riscv_dbg_unit;

  localparam int XLEN = 64;
  localparam int PLEN = 64;
  localparam int BP   = 3;
  localparam int EXC  = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dbg_stall_i = 1'b0, dbg_stb_i = 1'b0, dbg_we_i = 1'b0;
  logic [PLEN-1:0] dbg_adr_i = '0;
  logic [XLEN-1:0] dbg_dat_i = '0, dbg_dat_o;
  logic dbg_ack_o, dbg_bp_o;
  logic ex_valid_i = 1'b0, ex_branch_i = 1'b0;
  logic [PLEN-1:0] ex_pc_i = '0;
  logic [EXC-1:0]  ex_exception_i = '0;
  logic mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [PLEN-1:0] mem_adr_i = '0;
  logic du_stall_o, du_flush_o, du_re_rf_o, du_we_rf_o, du_re_csr_o, du_we_csr_o, du_we_pc_o;
  logic [11:0]     du_addr_o;
  logic [XLEN-1:0] du_dato_o;
  logic [XLEN-1:0] du_dati_rf_i  = 64'h1234;
  logic [XLEN-1:0] du_dati_csr_i = 64'h0000_0000_C5C5_0001;
  logic [XLEN-1:0] du_npc_i      = 64'h8000_0400;
  logic [XLEN-1:0] du_ppc_i      = 64'h8000_03FC;

  always #5 clk = ~clk;

  riscv_dbg_unit #(.XLEN(XLEN), .PLEN(PLEN), .BREAKPOINTS(BP), .EXC(EXC)) dut (
    .clk(clk), .rstn(rstn), .dbg_stall_i(dbg_stall_i), .dbg_stb_i(dbg_stb_i),
    .dbg_we_i(dbg_we_i), .dbg_adr_i(dbg_adr_i), .dbg_dat_i(dbg_dat_i),
    .dbg_dat_o(dbg_dat_o), .dbg_ack_o(dbg_ack_o), .dbg_bp_o(dbg_bp_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_branch_i(ex_branch_i),
    .ex_exception_i(ex_exception_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_adr_i(mem_adr_i), .du_stall_o(du_stall_o), .du_flush_o(du_flush_o),
    .du_re_rf_o(du_re_rf_o), .du_we_rf_o(du_we_rf_o), .du_re_csr_o(du_re_csr_o),
    .du_we_csr_o(du_we_csr_o), .du_we_pc_o(du_we_pc_o), .du_addr_o(du_addr_o),
    .du_dato_o(du_dato_o), .du_dati_rf_i(du_dati_rf_i), .du_dati_csr_i(du_dati_csr_i),
    .du_npc_i(du_npc_i), .du_ppc_i(du_ppc_i)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] rd_q[$];
  logic seen_re_rf, seen_we_rf, seen_we_pc;
  logic [11:0] seen_addr;
  logic [63:0] seen_dato;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus access; reads pop their expected value from rd_q at ack.
  task automatic xfer(input logic we, input logic [63:0] adr, input logic [63:0] wdat);
    int lat;
    bit got;
    logic [63:0] exp;
    seen_re_rf = 0; seen_we_rf = 0; seen_we_pc = 0; seen_addr = '0; seen_dato = '0;
    @(negedge clk);
    dbg_stb_i = 1'b1; dbg_we_i = we; dbg_adr_i = adr; dbg_dat_i = wdat;
    lat = 0; got = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (dbg_ack_o) got = 1;
      else begin
        if (du_re_rf_o) seen_re_rf = 1;
        if (du_we_rf_o) seen_we_rf = 1;
        if (du_we_pc_o) seen_we_pc = 1;
        if (du_re_rf_o | du_we_rf_o | du_we_pc_o | du_re_csr_o | du_we_csr_o) begin
          seen_addr = du_addr_o; seen_dato = du_dato_o;
        end
      end
    end
    if (!got) begin
      check("ack_timeout", 64'd0, 64'd1);
      if (!we && rd_q.size() > 0) void'(rd_q.pop_front());
    end else begin
      check("ack_latency", 64'(lat), 64'd2);
      if (!we && rd_q.size() > 0) begin
        exp = rd_q.pop_front();
        check($sformatf("rdata@%0h", adr), dbg_dat_o, exp);
      end
    end
    @(negedge clk);
    check("no_second_ack", {63'b0, dbg_ack_o}, 64'd0);
    dbg_stb_i = 1'b0; dbg_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [63:0] adr, input logic [63:0] exp);
    rd_q.push_back(exp);
    xfer(1'b0, adr, '0);
  endtask

  task automatic hit_chk(input string tag, input logic exp_hit);
    @(negedge clk);
    ex_valid_i = 0; ex_branch_i = 0; ex_exception_i = '0; mem_req_i = 0; mem_we_i = 0;
    check({tag, "_bp"}, {63'b0, dbg_bp_o}, {63'b0, exp_hit});
    check({tag, "_stall"}, {63'b0, du_stall_o}, {63'b0, exp_hit});
    @(negedge clk);
    check({tag, "_bp_end"}, {63'b0, dbg_bp_o}, 64'd0);
  endtask

  initial begin
    dbg_stb_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ack", {63'b0, dbg_ack_o}, 64'd0);
      check("rst_outs", {57'b0, dbg_bp_o, du_flush_o, du_stall_o, du_re_rf_o,
                         du_we_rf_o, du_we_pc_o, |du_addr_o}, 64'd0);
      check("rst_dat", dbg_dat_o, 64'd0);
    end
    dbg_stb_i = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    xfer(1'b1, 64'h0000, 64'h1);
    rd(64'h0000, 64'h1);
    xfer(1'b1, 64'h0000, 64'h0);

    dbg_stall_i = 1'b1;
    xfer(1'b1, 64'h1005, 64'hDEADBEEF);
    check("gpr_we", {63'b0, seen_we_rf}, 64'd1);
    check("gpr_addr", {52'b0, seen_addr}, 64'd5);
    check("gpr_dato", seen_dato, 64'hDEADBEEF);
    rd(64'h1005, 64'h1234);
    check("gpr_re", {63'b0, seen_re_rf}, 64'd1);
    rd(64'h3305, 64'h0000_0000_C5C5_0001);
    @(negedge clk);
    dbg_stall_i = 1'b0;
    @(negedge clk);
    check("no_flush_wo_pc", {63'b0, du_flush_o}, 64'd0);

    rd(64'h1003, 64'h0);
    check("gpr_re_nostall", {63'b0, seen_re_rf}, 64'd0);
    rd(64'h0500, 64'h0);

    xfer(1'b1, 64'h0011, 64'h8000_0100);
    xfer(1'b1, 64'h0010, 64'hF9);
    rd(64'h0010, 64'h1);
    rd(64'h0011, 64'h8000_0100);
    @(negedge clk); ex_valid_i = 1; ex_pc_i = 64'h8000_0100;
    hit_chk("bp0", 1'b1);
    rd(64'h0001, 64'h10);
    xfer(1'b1, 64'h0001, 64'h10);
    rd(64'h0001, 64'h0);

    xfer(1'b1, 64'h0013, 64'h0000_1000);
    xfer(1'b1, 64'h0012, 64'h5);
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_adr_i = 64'h1000;
    hit_chk("bp1_read", 1'b0);
    @(negedge clk); mem_req_i = 1; mem_we_i = 1; mem_adr_i = 64'h1000;
    hit_chk("bp1_write", 1'b1);
    rd(64'h0001, 64'h20);

    xfer(1'b1, 64'h0002, 64'h8);
    @(negedge clk); ex_exception_i = 16'h0004;
    hit_chk("exc_masked", 1'b0);
    @(negedge clk); ex_exception_i = 16'h0008;
    hit_chk("exc_hit", 1'b1);
    rd(64'h0003, 64'd3);
    rd(64'h0001, 64'h24);

    dbg_stall_i = 1'b1;
    xfer(1'b1, 64'h2000, 64'h8000_0200);
    check("npc_we", {63'b0, seen_we_pc}, 64'd1);
    check("npc_dato", seen_dato, 64'h8000_0200);
    rd(64'h2001, 64'h8000_03FC);
    xfer(1'b1, 64'h2001, 64'h1111);
    check("ppc_ro_no_we", {63'b0, seen_we_pc}, 64'd0);
    @(negedge clk);
    check("flush_during_stall", {63'b0, du_flush_o}, 64'd0);
    dbg_stall_i = 1'b0;
    @(negedge clk);
    check("flush_pulse", {63'b0, du_flush_o}, 64'd1);
    @(negedge clk);
    check("flush_end", {63'b0, du_flush_o}, 64'd0);

    check("sb_empty", 64'(rd_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
